wb_stage_ctrl: RTL and testbench
================================

// Module: wb_stage_ctrl
// PURPOSE
//  Registered, parametrised write-back stage between MEM stage and register file.
//  Selects ALU result, load data or link value; sign/zero-extends byte loads.
//  Waits on variable-latency memory read data with backpressure to MEM stage.
//  Publishes in-flight load destination for the hazard unit.
// PARAMETERS
//  DATA_W      16    datapath / register width (>=16, even)
//  RADDR_W     3     register-file address width
//  TIMEOUT     15    max cycles waiting for mem_rvalid before abort (1..2^CNT_W-1)
//  CNT_W       4     wait-counter width
//  ZERO_REG    1     1: writes to register 0 suppressed
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        MEM stage presents an instruction
//  in_ready     out  1        stage can accept (combinational: state==IDLE)
//  in_we        in   1        instruction writes a register
//  in_sel       in   2        00 ALU, 01 load, 10 link, 11 reserved (treated as no write)
//  in_rd        in   RADDR_W  destination register
//  in_ld_byte   in   1        load is a byte (low 8 bits of mem_rdata)
//  in_ld_signed in   1        byte load sign-extends
//  in_alu       in   DATA_W   ALU result
//  in_link      in   DATA_W   link (return) value
//  mem_rvalid   in   1        load data valid, single-cycle pulse
//  mem_rdata    in   DATA_W   load data
//  rf_we        out  1        register-file write strobe
//  rf_waddr     out  RADDR_W  write address
//  rf_wdata     out  DATA_W   write data (also forwarding source)
//  pend_valid   out  1        load in flight (state==WAIT_MEM)
//  pend_rd      out  RADDR_W  its destination
//  err_timeout  out  1        sticky: a load timed out
//  err_spurious out  1        sticky: mem_rvalid while not waiting
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counter 0, sticky flags cleared.
//  Accept = in_valid & in_ready. States IDLE, WAIT_MEM.
//  IDLE, accept, sel ALU/link, we=1: next cycle rf_we=1, rf_waddr=in_rd,
//   rf_wdata=in_alu/in_link. Stay IDLE; back-to-back accepts, 1 write/cycle.
//  IDLE, accept, we=0 or sel=11: no write (rf_we=0 next cycle), stay IDLE.
//  IDLE, accept, sel load, we=1: latch rd/byte/signed; go WAIT_MEM; counter=0.
//   Load with we=0: treated as no write; no wait.
//  WAIT_MEM: in_ready=0, pend_valid=1, pend_rd=latched rd; counter +1/cycle.
//   mem_rvalid: next cycle rf_we=1 with extended data, state IDLE (in_ready
//   high from that cycle; min load-to-write latency 2 cycles after accept).
//   Extension: byte -> low 8 bits, upper bits = bit7 if signed else 0;
//   word -> mem_rdata unchanged.
//   Counter reaching TIMEOUT without mem_rvalid: set err_timeout, no write,
//   return IDLE. mem_rvalid on same cycle as timeout: data wins, no error.
//  mem_rvalid in IDLE: ignored for write, sets err_spurious (same cycle as an
//   accept too: accepted instr proceeds normally).
//  ZERO_REG=1 and rd==0: rf_we forced 0; pend_valid still asserted for loads.
//  rf_we high exactly one cycle per write; rf_waddr/rf_wdata hold last values
//   when rf_we=0.
//  Async reset mid-WAIT_MEM: abandons load, no write; later rvalid -> spurious.
// TESTING
//  ALU ops rd=1 0x1234, rd=2 0xBEEF on consecutive cycles -> rf_we 2 cycles,
//   data 0x1234 then 0xBEEF, in_ready constant 1.
//  Signed byte load rd=3, rvalid 3 cycles later data 0x0080 -> pend_valid 3
//   cycles, then rf_wdata=0xFF80; unsigned same -> 0x0080; word -> 0x0080.
//  Load rd=4, no rvalid -> after TIMEOUT=15 cycles err_timeout=1, no rf_we,
//   in_ready returns 1; rvalid exactly at count 15 -> write, no error.
//  Link to rd=0 with ZERO_REG=1 -> rf_we stays 0; ZERO_REG=0 -> write 0x0042.
//  rvalid pulse while IDLE -> err_spurious=1, no write; held until reset.
//  rst_n low during WAIT_MEM -> outputs 0 immediately; rvalid after release
//   -> no write, err_spurious=1; DATA_W=32 run repeats scenario 2 (0xFFFFFF80).

Source files
------------

// File: rtl/wb_stage_ctrl_if.sv
// Bus between the MEM stage, the write-back stage and the register file.
// The slave modport is the write-back stage's view of the bus.
interface wb_stage_ctrl_if #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
);
  logic               in_valid;
  logic               in_ready;
  logic               in_we;
  logic [1:0]         in_sel;
  logic [RADDR_W-1:0] in_rd;
  logic               in_ld_byte;
  logic               in_ld_signed;
  logic [DATA_W-1:0]  in_alu;
  logic [DATA_W-1:0]  in_link;
  logic               mem_rvalid;
  logic [DATA_W-1:0]  mem_rdata;
  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic               pend_valid;
  logic [RADDR_W-1:0] pend_rd;
  logic               err_timeout;
  logic               err_spurious;

  modport master (
    output in_valid, in_we, in_sel, in_rd, in_ld_byte, in_ld_signed,
           in_alu, in_link, mem_rvalid, mem_rdata,
    input  in_ready, rf_we, rf_waddr, rf_wdata, pend_valid, pend_rd,
           err_timeout, err_spurious
  );

  modport slave (
    input  in_valid, in_we, in_sel, in_rd, in_ld_byte, in_ld_signed,
           in_alu, in_link, mem_rvalid, mem_rdata,
    output in_ready, rf_we, rf_waddr, rf_wdata, pend_valid, pend_rd,
           err_timeout, err_spurious
  );
endinterface

// File: rtl/wb_stage_ctrl.sv
// Write-back stage: selects ALU/load/link result, waits on variable-latency
// load data with a timeout, and publishes the in-flight load destination.
module wb_stage_ctrl #(
  parameter int DATA_W   = 16,
  parameter int RADDR_W  = 3,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  wb_stage_ctrl_if.slave bus
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [RADDR_W-1:0] ld_rd;
  logic               ld_byte;
  logic               ld_signed;
  logic               accept;
  logic               wr_req;
  logic [RADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [DATA_W-1:0]  ld_data;

  // Gated by rst_n so every output reads 0 while reset is held.
  assign bus.in_ready   = rst_n & (state == IDLE);
  assign accept         = bus.in_valid & (state == IDLE);
  assign bus.pend_valid = (state == WAIT_MEM);
  assign bus.pend_rd    = ld_rd;

  always_comb begin
    ld_data = bus.mem_rdata;
    if (ld_byte)
      ld_data = {{(DATA_W-8){ld_signed & bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
  end

  always_comb begin
    wr_req  = 1'b0;
    wr_addr = bus.in_rd;
    wr_data = bus.in_alu;
    if (state == WAIT_MEM) begin
      wr_req  = bus.mem_rvalid;
      wr_addr = ld_rd;
      wr_data = ld_data;
    end else if (accept && bus.in_we) begin
      unique case (bus.in_sel)
        2'b00:   wr_req = 1'b1;
        2'b10: begin
          wr_req  = 1'b1;
          wr_data = bus.in_link;
        end
        default: wr_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      ld_rd            <= '0;
      ld_byte          <= 1'b0;
      ld_signed        <= 1'b0;
      bus.rf_we        <= 1'b0;
      bus.rf_waddr     <= '0;
      bus.rf_wdata     <= '0;
      bus.err_timeout  <= 1'b0;
      bus.err_spurious <= 1'b0;
    end else begin
      bus.rf_we <= 1'b0;
      // Address/data only move on a real write so they hold otherwise.
      if (wr_req && !(ZERO_REG && wr_addr == '0)) begin
        bus.rf_we    <= 1'b1;
        bus.rf_waddr <= wr_addr;
        bus.rf_wdata <= wr_data;
      end

      unique case (state)
        IDLE: begin
          if (bus.mem_rvalid)
            bus.err_spurious <= 1'b1;
          if (accept && bus.in_we && bus.in_sel == 2'b01) begin
            state     <= WAIT_MEM;
            cnt       <= '0;
            ld_rd     <= bus.in_rd;
            ld_byte   <= bus.in_ld_byte;
            ld_signed <= bus.in_ld_signed;
          end
        end
        WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            state <= IDLE;
            ld_rd <= '0;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            state           <= IDLE;
            ld_rd           <= '0;
            bus.err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Bench for wb_stage_ctrl: a 16-bit ZERO_REG=1 and a 32-bit ZERO_REG=0 instance
// share one stimulus stream and are checked every cycle against a reference model.
module tb_wb_stage_ctrl;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_ctrl_if #(.DATA_W(16), .RADDR_W(3)) b0 ();
  wb_stage_ctrl_if #(.DATA_W(32), .RADDR_W(3)) b1 ();

  wb_stage_ctrl #(.DATA_W(16), .RADDR_W(3), .TIMEOUT(TO), .CNT_W(4), .ZERO_REG(1'b1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  wb_stage_ctrl #(.DATA_W(32), .RADDR_W(3), .TIMEOUT(TO), .CNT_W(4), .ZERO_REG(1'b0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int n_pass = 0;
  int n_total = 0;

  // shared stimulus
  logic        s_valid, s_we, s_byte, s_sgn, s_rv;
  logic [1:0]  s_sel;
  logic [2:0]  s_rd;
  logic [31:0] s_alu, s_link, s_rdata;

  // model state, index 0 = 16-bit/ZERO_REG=1, index 1 = 32-bit/ZERO_REG=0
  bit          m_wait[2];
  int          m_cnt[2];
  logic [2:0]  m_lrd[2];
  bit          m_lbyte[2], m_lsgn[2];
  bit          e_we[2], e_eto[2], e_esp[2];
  logic [2:0]  e_waddr[2];
  logic [31:0] e_wdata[2];

  function automatic logic [31:0] dmask(int d);
    return (d == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] load_value(int d, logic [31:0] raw, bit byt, bit sgn);
    logic [31:0] v;
    if (!byt) return raw & dmask(d);
    v = raw & 32'h0000_00FF;
    if (sgn && v >= 32'h80) v = v | (dmask(d) & 32'hFFFF_FF00);
    return v;
  endfunction

  task automatic model_write(int d, logic [2:0] rd, logic [31:0] val);
    if (d == 0 && rd == 3'd0) return;
    e_we[d]    = 1'b1;
    e_waddr[d] = rd;
    e_wdata[d] = val & dmask(d);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_wait[d] = 0; m_cnt[d] = 0; m_lrd[d] = '0; m_lbyte[d] = 0; m_lsgn[d] = 0;
      e_we[d] = 0; e_eto[d] = 0; e_esp[d] = 0; e_waddr[d] = '0; e_wdata[d] = '0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      e_we[d] = 1'b0;
      if (m_wait[d]) begin
        if (s_rv) begin
          model_write(d, m_lrd[d], load_value(d, s_rdata, m_lbyte[d], m_lsgn[d]));
          m_wait[d] = 0;
        end else if (m_cnt[d] == TO) begin
          e_eto[d]  = 1'b1;
          m_wait[d] = 0;
        end else begin
          m_cnt[d]++;
        end
      end else begin
        if (s_rv) e_esp[d] = 1'b1;
        if (s_valid && s_we) begin
          if (s_sel == 2'b00) model_write(d, s_rd, s_alu);
          else if (s_sel == 2'b10) model_write(d, s_rd, s_link);
          else if (s_sel == 2'b01) begin
            m_wait[d] = 1; m_cnt[d] = 0; m_lrd[d] = s_rd;
            m_lbyte[d] = s_byte; m_lsgn[d] = s_sgn;
          end
        end
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
  endtask

  task automatic cmp_dut(int d, logic rdy, logic we, logic [2:0] wa, logic [31:0] wd,
                         logic pv, logic [2:0] prd, logic eto, logic esp);
    check($sformatf("in_ready[%0d]", d), 32'(rdy), 32'(rst_n && !m_wait[d]));
    check($sformatf("rf_we[%0d]", d), 32'(we), 32'(e_we[d]));
    check($sformatf("rf_waddr[%0d]", d), 32'(wa), 32'(e_waddr[d]));
    check($sformatf("rf_wdata[%0d]", d), wd, e_wdata[d]);
    check($sformatf("pend_valid[%0d]", d), 32'(pv), 32'(m_wait[d]));
    check($sformatf("pend_rd[%0d]", d), 32'(prd), 32'(m_wait[d] ? m_lrd[d] : 3'd0));
    check($sformatf("err_timeout[%0d]", d), 32'(eto), 32'(e_eto[d]));
    check($sformatf("err_spurious[%0d]", d), 32'(esp), 32'(e_esp[d]));
  endtask

  task automatic compare();
    cmp_dut(0, b0.in_ready, b0.rf_we, b0.rf_waddr, 32'(b0.rf_wdata), b0.pend_valid,
            b0.pend_rd, b0.err_timeout, b0.err_spurious);
    cmp_dut(1, b1.in_ready, b1.rf_we, b1.rf_waddr, b1.rf_wdata, b1.pend_valid,
            b1.pend_rd, b1.err_timeout, b1.err_spurious);
  endtask

  task automatic apply();
    b0.in_valid = s_valid; b0.in_we = s_we; b0.in_sel = s_sel; b0.in_rd = s_rd;
    b0.in_ld_byte = s_byte; b0.in_ld_signed = s_sgn; b0.in_alu = s_alu[15:0];
    b0.in_link = s_link[15:0]; b0.mem_rvalid = s_rv; b0.mem_rdata = s_rdata[15:0];
    b1.in_valid = s_valid; b1.in_we = s_we; b1.in_sel = s_sel; b1.in_rd = s_rd;
    b1.in_ld_byte = s_byte; b1.in_ld_signed = s_sgn; b1.in_alu = s_alu;
    b1.in_link = s_link; b1.mem_rvalid = s_rv; b1.mem_rdata = s_rdata;
  endtask

  task automatic cycle();
    apply();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_in(bit rv, logic [31:0] rdata);
    s_valid = 0; s_we = 0; s_sel = 2'b00; s_rd = '0; s_byte = 0; s_sgn = 0;
    s_rv = rv; s_rdata = rdata;
  endtask

  task automatic issue(bit we, logic [1:0] sel, logic [2:0] rd, bit byt, bit sgn,
                       logic [31:0] alu, logic [31:0] link);
    s_valid = 1; s_we = we; s_sel = sel; s_rd = rd; s_byte = byt; s_sgn = sgn;
    s_alu = alu; s_link = link; s_rv = 0;
  endtask

  // Accept a load, idle for 'waits' cycles, then deliver data.
  task automatic load_run(logic [2:0] rd, bit byt, bit sgn, int waits, logic [31:0] data);
    issue(1, 2'b01, rd, byt, sgn, '0, '0);
    cycle();
    for (int i = 0; i < waits; i++) begin
      idle_in(0, '0);
      cycle();
    end
    idle_in(1, data);
    cycle();
    idle_in(0, '0);
  endtask

  initial begin
    s_alu = '0; s_link = '0;
    idle_in(0, '0);
    model_reset();
    apply();
    repeat (2) @(negedge clk);
    compare();
    check("reset_in_ready", 32'(b0.in_ready), 32'd0);
    rst_n = 1'b1;

    issue(1, 2'b00, 3'd1, 0, 0, 32'h0000_1234, '0);
    cycle();
    check("alu1_we", 32'(b0.rf_we), 32'd1);
    check("alu1_data", 32'(b0.rf_wdata), 32'h1234);
    issue(1, 2'b00, 3'd2, 0, 0, 32'h0000_BEEF, '0);
    cycle();
    check("alu2_data", 32'(b0.rf_wdata), 32'hBEEF);
    check("alu2_ready", 32'(b0.in_ready), 32'd1);
    idle_in(0, '0);
    cycle();

    load_run(3'd3, 1, 1, 2, 32'h0000_0080);
    check("sbyte16", 32'(b0.rf_wdata), 32'hFF80);
    check("sbyte32", b1.rf_wdata, 32'hFFFF_FF80);
    load_run(3'd3, 1, 0, 2, 32'h0000_0080);
    check("ubyte", 32'(b0.rf_wdata), 32'h0080);
    load_run(3'd3, 0, 0, 2, 32'h0000_0080);
    check("word", 32'(b0.rf_wdata), 32'h0080);

    issue(1, 2'b01, 3'd4, 0, 0, '0, '0);
    cycle();
    idle_in(0, '0);
    repeat (TO + 1) cycle();
    check("timeout_flag", 32'(b0.err_timeout), 32'd1);
    check("timeout_nowrite", 32'(b0.rf_we), 32'd0);
    check("timeout_ready", 32'(b0.in_ready), 32'd1);

    load_run(3'd5, 0, 0, TO, 32'h0000_5A5A);
    check("late_data", 32'(b0.rf_wdata), 32'h5A5A);
    check("late_we", 32'(b0.rf_we), 32'd1);

    issue(1, 2'b10, 3'd0, 0, 0, '0, 32'h0000_0042);
    cycle();
    check("zreg_suppress", 32'(b0.rf_we), 32'd0);
    check("zreg_off_data", b1.rf_wdata, 32'h42);

    idle_in(1, 32'h0000_7777);
    cycle();
    check("spurious", 32'(b0.err_spurious), 32'd1);
    idle_in(0, '0);

    issue(1, 2'b01, 3'd6, 0, 0, '0, '0);
    cycle();
    idle_in(0, '0);
    cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    check("rst_pend", 32'(b1.pend_valid), 32'd0);
    cycle();
    rst_n = 1'b1;
    idle_in(1, 32'h0000_1111);
    cycle();
    check("rst_spurious", 32'(b1.err_spurious), 32'd1);
    check("rst_nowrite", 32'(b1.rf_we), 32'd0);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        cycle();
        rst_n = 1'b1;
      end
      s_valid = ($urandom_range(0, 99) < 70);
      s_we    = ($urandom_range(0, 99) < 85);
      s_sel   = 2'($urandom_range(0, 3));
      s_rd    = 3'($urandom_range(0, 7));
      s_byte  = 1'($urandom_range(0, 1));
      s_sgn   = 1'($urandom_range(0, 1));
      s_alu   = $urandom();
      s_link  = $urandom();
      s_rv    = ($urandom_range(0, 99) < 8);
      s_rdata = $urandom();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
